// File: rtl/prng_ctrl_pkg.sv
// Shared types and sizing helpers for the PRNG word dispatcher.
// Contents: controller state enum, default parameter values, derived widths
// for the default configuration, and width helper functions.
package prng_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_WARMUP = 2'd0,
      ST_FILL   = 2'd1,
      ST_SERVE  = 2'd2
   } state_e;

   localparam int unsigned N_REQ_DEF  = 4;
   localparam int unsigned PRNG_W_DEF = 128;
   localparam int unsigned WORD_W_DEF = 32;
   localparam int unsigned WARMUP_DEF = 16;
   localparam int unsigned CNT_W_DEF  = 32;

   // Index width that never collapses to zero bits.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

   function automatic int unsigned words_of(input int unsigned prng_w, input int unsigned word_w);
      return prng_w / word_w;
   endfunction

   localparam int unsigned WORDS = words_of(PRNG_W_DEF, WORD_W_DEF);
   localparam int unsigned PTR_W = clog2_min1(WORDS);
   localparam int unsigned RR_W  = clog2_min1(N_REQ_DEF);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Ports:
//   req   - request vector
//   prio  - index of the requester with highest priority this cycle
//   en    - selection enable; no grant when low
//   gnt_c - one-hot grant
//   idx_c - encoded index of the granted requester
//   any_c - a grant was made
module rr_arbiter
   import prng_ctrl_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF,
   parameter int unsigned IDX_W = clog2_min1(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] prio,
   input  logic             en,
   output logic [N_REQ-1:0] gnt_c,
   output logic [IDX_W-1:0] idx_c,
   output logic             any_c
);

   logic [IDX_W-1:0] cand;

   // Walk from the priority index, wrapping, and take the first active request.
   always_comb begin
      gnt_c = '0;
      idx_c = '0;
      any_c = 1'b0;
      cand  = '0;
      if (en) begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((32'(prio) + i) % N_REQ);
            if (!any_c && req[cand]) begin
               any_c       = 1'b1;
               idx_c       = cand;
               gnt_c[cand] = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/prng_word_dispatcher.sv
// Sequences the NLFSR PRNG and shares each generated word between requesters.
// After reset the generator is advanced WARMUP times, then one PRNG_W word is
// captured and handed out WORD_W bits at a time, one slice per round-robin grant.
// Ports:
//   clk, rst    - clock, asynchronous active-low reset
//   prng_data   - current generator output
//   prng_en     - generator advance enable
//   req         - request levels, held until granted
//   gnt         - one-hot grant pulse
//   rnd_data    - slice delivered with gnt
//   rnd_valid   - any grant this cycle
//   busy        - warm-up or refill in progress
//   served_cnt  - total slices delivered (wrapping)
module prng_word_dispatcher
   import prng_ctrl_pkg::*;
#(
   parameter int unsigned N_REQ  = N_REQ_DEF,
   parameter int unsigned PRNG_W = PRNG_W_DEF,
   parameter int unsigned WORD_W = WORD_W_DEF,
   parameter int unsigned WARMUP = WARMUP_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PRNG_W-1:0] prng_data,
   output logic              prng_en,
   input  logic [N_REQ-1:0]  req,
   output logic [N_REQ-1:0]  gnt,
   output logic [WORD_W-1:0] rnd_data,
   output logic              rnd_valid,
   output logic              busy,
   output logic [CNT_W-1:0]  served_cnt
);

   localparam int unsigned N_WORDS = words_of(PRNG_W, WORD_W);
   localparam int unsigned P_W     = clog2_min1(N_WORDS);
   localparam int unsigned I_W     = clog2_min1(N_REQ);
   localparam int unsigned WC_W    = clog2_min1(WARMUP);

   state_e                          state_q, state_d;
   logic [WC_W-1:0]                 warm_q, warm_d;
   logic [P_W-1:0]                  ptr_q, ptr_d;
   logic [I_W-1:0]                  prio_q, prio_d;
   logic [N_WORDS-1:0][WORD_W-1:0]  buf_q, buf_d;
   logic [N_REQ-1:0]                gnt_q, gnt_d;
   logic [WORD_W-1:0]               rnd_data_q, rnd_data_d;
   logic                            valid_q, valid_d;
   logic                            busy_q, busy_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic                            prng_en_c;

   logic [N_REQ-1:0]                arb_gnt;
   logic [I_W-1:0]                  arb_idx;
   logic                            arb_any;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (I_W)
   ) u_arb (
      .req   (req),
      .prio  (prio_q),
      .en    (state_q == ST_SERVE),
      .gnt_c (arb_gnt),
      .idx_c (arb_idx),
      .any_c (arb_any)
   );

   // Next-state and registered-output computation.
   always_comb begin
      state_d    = state_q;
      warm_d     = warm_q;
      ptr_d      = ptr_q;
      prio_d     = prio_q;
      buf_d      = buf_q;
      gnt_d      = '0;
      valid_d    = 1'b0;
      rnd_data_d = rnd_data_q;
      cnt_d      = cnt_q;
      // busy tracks the state whose results are visible on the registered outputs,
      // so the last grant of a buffer is never flagged busy.
      busy_d     = (state_q != ST_SERVE);
      prng_en_c  = 1'b0;

      case (state_q)
         ST_WARMUP: begin
            prng_en_c = 1'b1;
            if (warm_q == WC_W'(WARMUP - 1)) begin
               warm_d  = '0;
               state_d = ST_FILL;
            end else begin
               warm_d = warm_q + WC_W'(1);
            end
         end
         ST_FILL: begin
            // Capture and step the generator past the captured word.
            prng_en_c = 1'b1;
            buf_d     = prng_data;
            ptr_d     = '0;
            state_d   = ST_SERVE;
         end
         ST_SERVE: begin
            if (arb_any) begin
               gnt_d      = arb_gnt;
               valid_d    = 1'b1;
               rnd_data_d = buf_q[ptr_q];
               cnt_d      = cnt_q + CNT_W'(1);
               prio_d     = (arb_idx == I_W'(N_REQ - 1)) ? '0 : arb_idx + I_W'(1);
               ptr_d      = ptr_q + P_W'(1);
               if (ptr_q == P_W'(N_WORDS - 1)) begin
                  state_d = ST_FILL;
               end
            end
         end
         default: begin
            state_d = ST_WARMUP;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_WARMUP;
         warm_q     <= '0;
         ptr_q      <= '0;
         prio_q     <= '0;
         buf_q      <= '0;
         gnt_q      <= '0;
         rnd_data_q <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b1;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         warm_q     <= warm_d;
         ptr_q      <= ptr_d;
         prio_q     <= prio_d;
         buf_q      <= buf_d;
         gnt_q      <= gnt_d;
         rnd_data_q <= rnd_data_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         cnt_q      <= cnt_d;
      end
   end

   // Generator must not step while held in reset.
   assign prng_en    = prng_en_c & rst;
   assign gnt        = gnt_q;
   assign rnd_data   = rnd_data_q;
   assign rnd_valid  = valid_q;
   assign busy       = busy_q;
   assign served_cnt = cnt_q;

endmodule

// File: tb/tb_prng_word_dispatcher.sv
// Self-checking bench for prng_word_dispatcher: constant vector table for the
// start-up sequence, hand-written multi-cycle sequences, and a cycle scoreboard.
module tb_prng_word_dispatcher;

   localparam int unsigned N_REQ  = 4;
   localparam int unsigned PRNG_W = 128;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned WARMUP = 16;
   localparam int unsigned CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [PRNG_W-1:0] prng_data;
   logic              prng_en;
   logic [N_REQ-1:0]  req = '0;
   logic [N_REQ-1:0]  gnt;
   logic [WORD_W-1:0] rnd_data;
   logic              rnd_valid;
   logic              busy;
   logic [CNT_W-1:0]  served_cnt;

   int errors = 0;
   int checks = 0;

   prng_word_dispatcher #(
      .N_REQ  (N_REQ),
      .PRNG_W (PRNG_W),
      .WORD_W (WORD_W),
      .WARMUP (WARMUP),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .prng_data  (prng_data),
      .prng_en    (prng_en),
      .req        (req),
      .gnt        (gnt),
      .rnd_data   (rnd_data),
      .rnd_valid  (rnd_valid),
      .busy       (busy),
      .served_cnt (served_cnt)
   );

   always #5 clk = ~clk;

   // Generator stand-in: after k steps, slice j reads 4*(k-16)+j+1, so the
   // first capture after a 16-step warm-up from k=0 is 4,3,2,1 (msb..lsb).
   int unsigned g = 0;
   always @(posedge clk) if (prng_en) g <= g + 1;

   function automatic logic [PRNG_W-1:0] gen_word(input int unsigned k);
      logic [PRNG_W-1:0] w;
      w = '0;
      for (int j = 0; j < 4; j++) w[j*32 +: 32] = 32'(4 * (k - 16) + 32'(j) + 1);
      return w;
   endfunction

   assign prng_data = gen_word(g);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [3:0]  gnt;
      logic        valid;
      logic [31:0] data;
      logic [3:0]  cnt;
      logic        busy;
   } exp_t;

   exp_t         sbq[$];
   exp_t         m_e;
   exp_t         c_e;
   int           m_st;      // 0 warm-up, 1 refill, 2 serving
   int unsigned  m_w;
   int unsigned  m_ptr;
   logic [1:0]   m_prio;
   logic [1:0]   m_sel;
   logic [127:0] m_buf;
   logic [31:0]  m_last;
   logic [3:0]   m_cnt;

   // Reference model: predicts the registered outputs after each clock edge.
   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_st = 0; m_w = 0; m_ptr = 0; m_prio = 2'd0; m_buf = '0;
            m_last = '0; m_cnt = '0;
            sbq.delete();
         end else begin
            m_e.gnt  = '0;
            m_e.busy = (m_st != 2);
            case (m_st)
               0: begin
                  m_w++;
                  if (m_w == WARMUP) begin m_w = 0; m_st = 1; end
               end
               1: begin
                  m_buf = prng_data; m_ptr = 0; m_st = 2;
               end
               default: begin
                  if (req != 0) begin
                     m_sel = m_prio;
                     for (int i = 0; i < 4; i++) if (!req[m_sel]) m_sel = m_sel + 2'd1;
                     m_e.gnt = 4'd1 << m_sel;
                     m_last  = m_buf[m_ptr*32 +: 32];
                     m_cnt   = m_cnt + 4'd1;
                     m_prio  = m_sel + 2'd1;
                     m_ptr++;
                     if (m_ptr == 4) m_st = 1;
                  end
               end
            endcase
            m_e.valid = (m_e.gnt != 0);
            m_e.data  = m_last;
            m_e.cnt   = m_cnt;
            sbq.push_back(m_e);
         end
      end
   end

   // Compare DUT against the oldest prediction, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst && sbq.size() != 0) begin
            c_e = sbq.pop_front();
            check("sb_gnt", 32'(gnt), 32'(c_e.gnt));
            check("sb_valid", 32'(rnd_valid), 32'(c_e.valid));
            check("sb_data", rnd_data, c_e.data);
            check("sb_cnt", 32'(served_cnt), 32'(c_e.cnt));
            check("sb_busy", 32'(busy), 32'(c_e.busy));
            check("sb_prng_en", 32'(prng_en), 32'(m_st != 2));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequences ----------------
   typedef struct {
      logic [3:0]  req;
      logic        pen;
      logic        busy;
      logic [3:0]  gnt;
      logic [31:0] data;
      logic [3:0]  cnt;
   } vec_t;

   vec_t       tbl[24];
   logic [3:0] ord[7];
   logic       ok;
   int         n;
   int         pen_cnt;
   int unsigned g_rel;
   logic [3:0] last_g;
   int         age[4];

   task automatic wait_gnt(input int budget, output logic found);
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (gnt != 0) begin found = 1'b1; break; end
      end
      check("wait_gnt_in_budget", 32'(found), 32'd1);
   endtask

   initial begin
      // Start-up table: row k is cycle k after release; req is driven after sampling.
      for (int k = 0; k < 16; k++) tbl[k] = '{4'h0, 1'b1, 1'b1, 4'h0, 32'd0, 4'd0};
      tbl[16] = '{4'h1, 1'b1, 1'b1, 4'h0, 32'd0, 4'd0};
      tbl[17] = '{4'h1, 1'b0, 1'b1, 4'h0, 32'd0, 4'd0};
      tbl[18] = '{4'h1, 1'b0, 1'b0, 4'h1, 32'd1, 4'd1};
      tbl[19] = '{4'h1, 1'b0, 1'b0, 4'h1, 32'd2, 4'd2};
      tbl[20] = '{4'h1, 1'b0, 1'b0, 4'h1, 32'd3, 4'd3};
      tbl[21] = '{4'h1, 1'b1, 1'b0, 4'h1, 32'd4, 4'd4};
      tbl[22] = '{4'h1, 1'b0, 1'b1, 4'h0, 32'd4, 4'd4};
      tbl[23] = '{4'h0, 1'b0, 1'b0, 4'h1, 32'd5, 4'd5};
      ord = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2};

      // Values while held in reset.
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_valid", 32'(rnd_valid), 32'd0);
      check("rst_data", rnd_data, 32'd0);
      check("rst_cnt", 32'(served_cnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_prng_en", 32'(prng_en), 32'd0);

      // Warm-up, first fill and first burst.
      @(posedge clk); #1 rst = 1'b1;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         check($sformatf("tbl%0d_prng_en", k), 32'(prng_en), 32'(tbl[k].pen));
         check($sformatf("tbl%0d_busy", k), 32'(busy), 32'(tbl[k].busy));
         check($sformatf("tbl%0d_gnt", k), 32'(gnt), 32'(tbl[k].gnt));
         check($sformatf("tbl%0d_valid", k), 32'(rnd_valid), 32'(tbl[k].gnt != 0));
         check($sformatf("tbl%0d_data", k), rnd_data, tbl[k].data);
         check($sformatf("tbl%0d_cnt", k), 32'(served_cnt), 32'(tbl[k].cnt));
         req = tbl[k].req;
      end

      // All requesting: rr order across a refill, then served_cnt wrap.
      @(negedge clk); #1 rst = 1'b0;
      @(posedge clk); #1 rst = 1'b1; req = 4'hF;
      wait_gnt(40, ok);
      n = 0;
      if (ok) begin
         for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("rr1111_order%0d", i), 32'(gnt), 32'(ord[i]));
            if (gnt != 0) begin
               n++;
               check("cnt_sequence", 32'(served_cnt), 32'(n % 16));
            end
         end
         for (int i = 0; i < 40 && n < 16; i++) begin
            @(negedge clk);
            if (gnt != 0) begin
               n++;
               if (n == 15) check("cnt_at_15", 32'(served_cnt), 32'd15);
               if (n == 16) check("cnt_wrap_16", 32'(served_cnt), 32'd0);
            end
         end
      end
      check("wrap_grants_reached", 32'(n), 32'd16);

      // Reset after two slices of a buffer, then a clean restart.
      @(negedge clk); #1 rst = 1'b0; req = 4'h1;
      @(posedge clk); #1 rst = 1'b1;
      n = 0;
      for (int i = 0; i < 60 && n < 2; i++) begin
         @(negedge clk);
         if (gnt != 0) n++;
      end
      check("two_grants_seen", 32'(n), 32'd2);
      #1 rst = 1'b0;
      #1;
      check("midrst_gnt", 32'(gnt), 32'd0);
      check("midrst_valid", 32'(rnd_valid), 32'd0);
      check("midrst_data", rnd_data, 32'd0);
      check("midrst_cnt", 32'(served_cnt), 32'd0);
      check("midrst_busy", 32'(busy), 32'd1);
      check("midrst_prng_en", 32'(prng_en), 32'd0);
      @(posedge clk); #1 g_rel = g; rst = 1'b1;
      pen_cnt = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (!prng_en) break;
         pen_cnt++;
      end
      check("rewarm_prng_en_cycles", 32'(pen_cnt), 32'(WARMUP + 1));
      wait_gnt(40, ok);
      if (ok) check("restart_slice0", rnd_data, 32'(4 * g_rel + 1));

      // Two requesters held: strict alternation.
      req = 4'hA;
      last_g = '0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (gnt != 0) begin
            check("rr1010_member", 32'(gnt == 4'h2 || gnt == 4'h8), 32'd1);
            if (last_g != 0) check("rr1010_alternate", 32'(gnt != last_g), 32'd1);
            last_g = gnt;
         end
      end
      // Requester 2 joins mid-stream; the scoreboard checks its turn.
      req = 4'hE;
      repeat (15) @(negedge clk);

      // Random requesters with handshake; bounded wait per request.
      for (int i = 0; i < 4; i++) age[i] = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (gnt[i]) begin
               check($sformatf("no_starve_req%0d", i), 32'(age[i] <= 8), 32'd1);
               age[i] = 0;
            end else if (req[i]) begin
               age[i]++;
            end
         end
         req = (req & ~gnt) | (4'($urandom) & 4'($urandom) & ~gnt);
      end

      req = '0;
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
